// File: rtl/stepper_phase_decoder_pkg.sv
// Shared motor definitions: half-step coil patterns, decoder state and
// the pattern-to-index decode used by the step-bus monitor.
package stepper_phase_decoder_pkg;

    localparam logic [3:0] HS_PAT_0 = 4'b1000;
    localparam logic [3:0] HS_PAT_1 = 4'b1100;
    localparam logic [3:0] HS_PAT_2 = 4'b0100;
    localparam logic [3:0] HS_PAT_3 = 4'b0110;
    localparam logic [3:0] HS_PAT_4 = 4'b0010;
    localparam logic [3:0] HS_PAT_5 = 4'b0011;
    localparam logic [3:0] HS_PAT_6 = 4'b0001;
    localparam logic [3:0] HS_PAT_7 = 4'b1001;
    localparam logic [3:0] COIL_OFF = 4'b0000;

    typedef enum logic [1:0] {
        ST_NOREF = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } dec_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } hs_decode_t;

    // De-energized (0000) also reports valid=0; callers treat it separately.
    function automatic hs_decode_t hs_pattern_to_index(input logic [3:0] pat);
        hs_decode_t d;
        d.valid = 1'b1;
        d.idx   = 3'd0;
        case (pat)
            HS_PAT_0: d.idx = 3'd0;
            HS_PAT_1: d.idx = 3'd1;
            HS_PAT_2: d.idx = 3'd2;
            HS_PAT_3: d.idx = 3'd3;
            HS_PAT_4: d.idx = 3'd4;
            HS_PAT_5: d.idx = 3'd5;
            HS_PAT_6: d.idx = 3'd6;
            HS_PAT_7: d.idx = 3'd7;
            default:  d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/stepper_phase_decoder_stall_timer.sv
// Stall timer: counts cycles without restart, saturates at STALL_CYCLES-1
// and raises a registered flag while saturated.
module stepper_phase_decoder_stall_timer #(
    parameter int unsigned STALL_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_stalled
);

    localparam int unsigned          CNT_W   = $clog2(STALL_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(STALL_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_stalled;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_count_next = r_count;
        if (i_restart) begin
            w_count_next = '0;
        end else if (r_count != CNT_MAX) begin
            w_count_next = r_count + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count   <= '0;
            r_stalled <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_stalled <= (w_count_next == CNT_MAX);
        end
    end

    assign o_stalled = r_stalled;

endmodule

// File: rtl/stepper_phase_decoder.sv
// Receive-side monitor for a 4-bit half-step coil bus: tracks position and
// direction, pulses per step, and flags skipped/illegal patterns and stalls.
module stepper_phase_decoder
    import stepper_phase_decoder_pkg::*;
#(
    parameter int          POS_W        = 16,
    parameter int unsigned STALL_CYCLES = 50000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [3:0]              i_coil,
    input  logic                    i_zero_pos,
    input  logic                    i_clear_fault,
    output logic signed [POS_W-1:0] o_position,
    output logic                    o_dir,
    output logic                    o_step_pulse,
    output logic                    o_energized,
    output logic                    o_skip,
    output logic                    o_fault,
    output logic                    o_stalled
);

    dec_state_t       r_state;
    dec_state_t       w_state_next;
    logic [3:0]       r_coil_q;
    logic [3:0]       r_coil_prev;
    logic [2:0]       r_idx;
    logic [POS_W-1:0] r_position;
    logic             r_dir;
    logic             r_step_pulse;
    logic             r_energized;
    logic             r_skip;
    logic             r_fault;

    hs_decode_t       w_dec;
    logic             w_coil_nz;
    logic [2:0]       w_delta;
    logic             w_step;
    logic             w_fwd;
    logic             w_double;
    logic             w_skip_evt;
    logic             w_fault_evt;
    logic             w_idx_load;
    logic [POS_W-1:0] w_step_mag;
    logic             w_stall_restart;

    assign w_dec      = hs_pattern_to_index(r_coil_q);
    assign w_coil_nz  = (r_coil_q != COIL_OFF);
    assign w_delta    = w_dec.idx - r_idx;
    assign w_step_mag = w_double ? POS_W'(2) : POS_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_NOREF;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_NOREF: begin
                if (w_fault_evt)     w_state_next = ST_FAULT;
                else if (w_idx_load) w_state_next = ST_TRACK;
            end
            ST_TRACK: if (w_fault_evt)   w_state_next = ST_FAULT;
            ST_FAULT: if (i_clear_fault) w_state_next = ST_NOREF;
            default:                     w_state_next = ST_NOREF;
        endcase
    end

    // Per-cycle step decisions from the registered pattern and stored index.
    always_comb begin
        w_step      = 1'b0;
        w_fwd       = 1'b0;
        w_double    = 1'b0;
        w_skip_evt  = 1'b0;
        w_fault_evt = 1'b0;
        w_idx_load  = 1'b0;
        case (r_state)
            ST_NOREF: begin
                if (w_coil_nz) begin
                    if (w_dec.valid) w_idx_load  = 1'b1;
                    else             w_fault_evt = 1'b1;
                end
            end
            ST_TRACK: begin
                if (w_coil_nz) begin
                    if (!w_dec.valid) begin
                        w_fault_evt = 1'b1;
                    end else begin
                        w_idx_load = 1'b1;
                        case (w_delta)
                            3'd1: begin w_step = 1'b1; w_fwd = 1'b1; end
                            3'd7: begin w_step = 1'b1; end
                            3'd2: begin
                                w_step = 1'b1; w_fwd = 1'b1;
                                w_double = 1'b1; w_skip_evt = 1'b1;
                            end
                            3'd6: begin
                                w_step = 1'b1; w_double = 1'b1; w_skip_evt = 1'b1;
                            end
                            3'd4: begin
                                // Opposite pattern: direction is ambiguous.
                                w_fault_evt = 1'b1;
                                w_idx_load  = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_coil_q     <= COIL_OFF;
            r_coil_prev  <= COIL_OFF;
            r_idx        <= 3'd0;
            r_position   <= '0;
            r_dir        <= 1'b0;
            r_step_pulse <= 1'b0;
            r_energized  <= 1'b0;
            r_skip       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_coil_q     <= i_coil;
            r_coil_prev  <= r_coil_q;
            r_step_pulse <= w_step;
            r_energized  <= w_coil_nz;
            if (w_idx_load) r_idx <= w_dec.idx;
            if (w_step)     r_dir <= w_fwd;

            if (i_zero_pos) begin
                r_position <= '0;
            end else if (w_step) begin
                r_position <= w_fwd ? (r_position + w_step_mag)
                                    : (r_position - w_step_mag);
            end

            if (w_skip_evt)         r_skip <= 1'b1;
            else if (i_clear_fault) r_skip <= 1'b0;

            if (w_fault_evt)                                 r_fault <= 1'b1;
            else if (i_clear_fault && r_state == ST_FAULT)   r_fault <= 1'b0;
        end
    end

    assign w_stall_restart = (r_state == ST_FAULT) || !w_coil_nz ||
                             (r_coil_q != r_coil_prev);

    stepper_phase_decoder_stall_timer #(
        .STALL_CYCLES(STALL_CYCLES)
    ) u_stall_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_restart (w_stall_restart),
        .o_stalled (o_stalled)
    );

    assign o_position   = r_position;
    assign o_dir        = r_dir;
    assign o_step_pulse = r_step_pulse;
    assign o_energized  = r_energized;
    assign o_skip       = r_skip;
    assign o_fault      = r_fault;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Bench for stepper_phase_decoder: two instances (16-bit and 4-bit position,
// short stall timeout) driven in parallel and compared against a step model.
module tb_stepper_phase_decoder;

    localparam int STALL = 8;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [3:0]  i_coil = 4'b0000;
    logic        i_zero_pos = 1'b0;
    logic        i_clear_fault = 1'b0;

    logic [15:0] pos16;
    logic        dir16, step16, en16, skip16, fault16, stall16;
    logic [3:0]  pos4;
    logic        dir4, step4, en4, skip4, fault4, stall4;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    stepper_phase_decoder #(.POS_W(16), .STALL_CYCLES(STALL)) u_dut16 (
        .i_clk(clk), .i_rst(i_rst), .i_coil(i_coil), .i_zero_pos(i_zero_pos),
        .i_clear_fault(i_clear_fault), .o_position(pos16), .o_dir(dir16),
        .o_step_pulse(step16), .o_energized(en16), .o_skip(skip16),
        .o_fault(fault16), .o_stalled(stall16)
    );

    stepper_phase_decoder #(.POS_W(4), .STALL_CYCLES(STALL)) u_dut4 (
        .i_clk(clk), .i_rst(i_rst), .i_coil(i_coil), .i_zero_pos(i_zero_pos),
        .i_clear_fault(i_clear_fault), .o_position(pos4), .o_dir(dir4),
        .o_step_pulse(step4), .o_energized(en4), .o_skip(skip4),
        .o_fault(fault4), .o_stalled(stall4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] hs_seq [0:7] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                 4'b0010, 4'b0011, 4'b0001, 4'b1001};

    function automatic int hs_index(input logic [3:0] p);
        for (int i = 0; i < 8; i++) if (hs_seq[i] == p) return i;
        return -1;
    endfunction

    int         m_pos = 0;
    int         m_idx = 0;
    int         m_run = 0;
    bit         m_dir, m_step, m_en, m_skip, m_fault, m_stalled;
    bit         m_has_ref, m_faulted;
    logic [3:0] m_coil_q = 4'b0000;
    logic [3:0] m_prev_q = 4'b0000;

    always @(posedge clk) begin
        if (i_rst) begin
            m_pos = 0; m_idx = 0; m_run = 0;
            m_dir = 0; m_step = 0; m_en = 0; m_skip = 0; m_fault = 0; m_stalled = 0;
            m_has_ref = 0; m_faulted = 0;
            m_coil_q = 4'b0000; m_prev_q = 4'b0000;
        end else begin
            int  ix, d, amt;
            bit  nz, skip_evt, fault_evt, was_faulted;
            nz = (m_coil_q != 4'b0000);
            ix = hs_index(m_coil_q);
            amt = 0; skip_evt = 0; fault_evt = 0;
            was_faulted = m_faulted;
            if (m_faulted) begin
                if (i_clear_fault) begin m_faulted = 0; m_has_ref = 0; end
            end else if (nz) begin
                if (ix < 0) fault_evt = 1;
                else if (!m_has_ref) begin m_has_ref = 1; m_idx = ix; end
                else begin
                    d = (ix - m_idx + 8) % 8;
                    if (d == 4) fault_evt = 1;
                    else begin
                        if (d == 1) amt = 1;
                        if (d == 7) amt = -1;
                        if (d == 2) begin amt = 2; skip_evt = 1; end
                        if (d == 6) begin amt = -2; skip_evt = 1; end
                        m_idx = ix;
                    end
                end
            end
            if (fault_evt) m_faulted = 1;
            m_step = (amt != 0);
            if (m_step) m_dir = (amt > 0);
            m_pos  = i_zero_pos ? 0 : m_pos + amt;
            m_en   = nz;
            if (skip_evt) m_skip = 1;
            else if (i_clear_fault) m_skip = 0;
            m_fault = m_faulted;
            if (was_faulted || !nz || m_coil_q != m_prev_q) m_run = 0;
            else m_run = m_run + 1;
            m_stalled = (m_run >= STALL - 1);
            m_prev_q = m_coil_q;
            m_coil_q = i_coil;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] mp;
            mp = m_pos;
            check("position16", {16'b0, pos16}, {16'b0, mp[15:0]});
            check("position4",  {28'b0, pos4},  {28'b0, mp[3:0]});
            check("dir",        dir16,   m_dir);
            check("step_pulse", step16,  m_step);
            check("energized",  en16,    m_en);
            check("skip",       skip16,  m_skip);
            check("fault",      fault16, m_fault);
            check("stalled",    stall16, m_stalled);
            check("dut4_step",  step4,   m_step);
            check("dut4_fault", fault4,  m_fault);
            if (step16) n_pulses++;
        end
    end

    task automatic hold(input logic [3:0] c, input int n);
        i_coil = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        i_clear_fault = 1'b1;
        @(negedge clk);
        i_clear_fault = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus with literal pins ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_pos",   {16'b0, pos16}, 32'h0);
        check("rst_flags", {dir16, step16, en16, skip16, fault16, stall16}, 32'h0);
        i_rst = 1'b0;
        n_pulses = 0;

        // forward: reference, then two steps
        hold(4'b1000, 4);
        check("ref_no_count", {16'b0, pos16}, 32'h0);
        hold(4'b1100, 4);
        hold(4'b0100, 4);
        check("fwd_pos", {16'b0, pos16}, 32'd2);
        check("fwd_dir", dir16, 1'b1);
        check("fwd_pulses", n_pulses, 32'd2);

        // reverse through zero
        hold(4'b1100, 4);
        check("rev_pos1", {16'b0, pos16}, 32'd1);
        hold(4'b1000, 4);
        hold(4'b1001, 4);
        check("rev_neg1", {16'b0, pos16}, 32'h0000FFFF);
        check("rev_dir", dir16, 1'b0);

        // skipped half-step
        hold(4'b1000, 4);
        hold(4'b0100, 4);
        check("skip_pos", {16'b0, pos16}, 32'd2);
        check("skip_set", skip16, 1'b1);
        check("skip_nofault", fault16, 1'b0);
        pulse_clear();
        @(negedge clk);
        check("skip_cleared", skip16, 1'b0);

        // illegal pattern, frozen count, recovery via NOREF
        hold(4'b1010, 4);
        check("illegal_fault", fault16, 1'b1);
        hold(4'b0110, 4);
        hold(4'b0010, 4);
        check("fault_frozen", {16'b0, pos16}, 32'd2);
        hold(4'b0000, 3);
        pulse_clear();
        hold(4'b0110, 4);
        check("reref_fault", fault16, 1'b0);
        check("reref_no_count", {16'b0, pos16}, 32'd2);
        hold(4'b0010, 4);
        check("reref_count", {16'b0, pos16}, 32'd3);

        // stall detection
        i_coil = 4'b0011;
        repeat (8) @(negedge clk);
        check("stall_pre", stall16, 1'b0);
        @(negedge clk);
        check("stall_rise", stall16, 1'b1);
        hold(4'b0011, 3);
        check("stall_hold", stall16, 1'b1);
        hold(4'b0001, 2);
        check("stall_drop", stall16, 1'b0);
        hold(4'b0000, 20);
        check("stall_deenergized", stall16, 1'b0);
        check("deenergized", en16, 1'b0);

        // 4-bit wrap
        hold(4'b0001, 4);
        hold(4'b1001, 4);
        hold(4'b1000, 4);
        check("wrap_pre", {28'b0, pos4}, 32'd7);
        hold(4'b1100, 4);
        check("wrap_neg8", {28'b0, pos4}, 32'h8);
        check("wrap_pos16", {16'b0, pos16}, 32'd8);

        // zero_pos coincident with a step
        i_coil = 4'b0100;
        @(negedge clk);
        i_zero_pos = 1'b1;
        @(negedge clk);
        i_zero_pos = 1'b0;
        check("zero_pos", {16'b0, pos16}, 32'h0);
        check("zero_step", step16, 1'b1);
        hold(4'b0100, 2);
        hold(4'b0110, 4);
        check("after_zero", {16'b0, pos16}, 32'd1);

        // opposite pattern (delta 4)
        hold(4'b1001, 4);
        check("delta4_fault", fault16, 1'b1);
        check("delta4_pos", {16'b0, pos16}, 32'd1);

        // clear_fault colliding with a skip event
        hold(4'b0000, 3);
        pulse_clear();
        hold(4'b1000, 4);
        i_coil = 4'b0100;
        @(negedge clk);
        i_clear_fault = 1'b1;
        @(negedge clk);
        i_clear_fault = 1'b0;
        check("skip_wins", skip16, 1'b1);
        check("skip_wins_pos", {16'b0, pos16}, 32'd3);
        hold(4'b0100, 3);

        // mid-operation reset
        i_rst = 1'b1;
        @(negedge clk);
        check("midrst_pos", {16'b0, pos16}, 32'h0);
        check("midrst_flags", {dir16, step16, en16, skip16, fault16, stall16}, 32'h0);
        i_rst = 1'b0;
        hold(4'b0100, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stepper_phase_decoder.md
Name: stepper_phase_decoder

Overview:
- Receive-side monitor for the 4-bit stepper coil bus that the plate and crane motor controllers drive.
- Decodes the half-step coil sequence into direction, step pulses and a signed position count, and flags illegal or skipped patterns and stalls.
- One instance sits on each motor step bus.
- The pouring-state FSM uses it for position feedback, homing and fault detection; benches use it as a step-bus checker.

Parameters:
- POS_W, 16, width of the signed position counter.
- STALL_CYCLES, 50000, cycles an energized pattern may stay unchanged before `stalled` asserts. Minimum value is 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- coil  in  4  coil pattern from the motor controller, clk-domain
- zero_pos  in  1  one-cycle pulse: load position with 0 (homing)
- clear_fault  in  1  one-cycle pulse: clear `fault` and `skip`
- position  out  POS_W  signed step count since reset or zero_pos
- dir  out  1  direction of the last counted step: 1 = forward, 0 = reverse
- step_pulse  out  1  one-cycle pulse per counted step
- energized  out  1  registered pattern is non-zero
- skip  out  1  sticky: a half-step was skipped (delta ±2)
- fault  out  1  sticky: illegal pattern or ambiguous jump
- stalled  out  1  energized with no pattern change for STALL_CYCLES cycles

Behaviour:
- Half-step table, index 0..7:
  - 0 = 1000, 1 = 1100, 2 = 0100, 3 = 0110
  - 4 = 0010, 5 = 0011, 6 = 0001, 7 = 1001
- 0000 means de-energized and is legal. All other 7 codes are illegal.
- Reset: all outputs 0, state NOREF, stored index 0, stall counter 0.
- Pipeline:
  - coil is registered into coil_q each cycle.
  - coil_q is compared with the stored index on the next edge.
  - All outputs are registered, so a change on coil appears on the outputs 2 cycles later.
- States:
  - NOREF: no reference yet.
    - A legal non-zero coil_q stores its index and moves to TRACK. No count, no pulse.
    - An illegal coil_q moves to FAULT.
  - TRACK: compute delta = (idx_new - idx_stored) mod 8 whenever coil_q is non-zero.
    - delta 0: no action.
    - delta 1: position +1, dir=1, step_pulse.
    - delta 7: position -1, dir=0, step_pulse.
    - delta 2: position +2, dir=1, step_pulse for one cycle, set skip.
    - delta 6: position -2, dir=0, step_pulse for one cycle, set skip.
    - delta 4: set fault, move to FAULT, position unchanged.
    - Illegal code: set fault, move to FAULT.
    - Each legal code updates the stored index.
    - coil_q = 0000: stay in TRACK and keep the stored index. Re-energizing is compared against the stored index.
  - FAULT:
    - fault=1, no counting, stored index is not updated.
    - On clear_fault, move to NOREF.
- Position arithmetic: modular two's complement, POS_W bits. It wraps at +max → -min and the reverse; no saturation.
- zero_pos has priority over a same-cycle step: position = 0, while step_pulse and dir still update.
- clear_fault in the same cycle as a new fault or skip event: the new event wins and the flag stays 1.
- clear_fault while not in FAULT clears skip only.
- Stall counter:
  - Counts while energized and coil_q is unchanged.
  - Resets to 0 on any change of coil_q or when de-energized.
  - stalled=1 when the counter reaches STALL_CYCLES-1. It holds there (no wrap) and deasserts on the next change.
  - Inactive in FAULT.
- rst mid-operation returns everything to reset values on the next edge, regardless of state.

Decomposition:
- Shared motor package holds:
  - the half-step pattern constants (also used by plate_motor_ctrl and crane_motor_ctrl);
  - the decoder state enum (NOREF, TRACK, FAULT);
  - the pattern-to-index function, which returns a valid bit and a 3-bit index.
- One natural sub-module: stall_timer (counter with restart and saturate-flag, parameter STALL_CYCLES).

Test Plan:
- Reset, then coil 1000 → 1100 → 0100, each held 4 cycles → no pulse for the first pattern; position 1 then 2; dir=1; exactly 2 step_pulses, each 2 cycles after its coil change.
- From index 2, coil 1100 → 1000 → 1001 → position 2 → 1 → 0 → -1 (all-ones); dir=0.
- From index 0, coil 0100 (delta +2) → position +2, skip=1, fault=0. Then clear_fault → skip=0.
- From TRACK, coil 1010 → fault=1; subsequent legal steps leave position unchanged. clear_fault, then 0110 → NOREF re-reference, no count; the next step counts.
- STALL_CYCLES=8, coil held at 0011 → stalled rises on cycle 8 after the pattern is registered. A change to 0001 drops it. coil 0000 held for 20 cycles → stalled stays 0.
- POS_W=4 at position 7, one forward step → -8. zero_pos in the same cycle as a forward step → position 0, step_pulse=1.
